main_memory_responder: RTL
==========================

Name: main_memory_responder

Overview:
- Memory-side responder for the cache controller's ReadEnable/WriteEnable/ready handshake.
- Accepts a block-fill read or a write-through single-word write, models a fixed multi-cycle memory latency, then pulses ready.
- Sits between the cache controller and main-memory storage.
- Returns a full cache block on reads and updates one word on writes.

Parameters:
- ADDR_W, 10: word-address width; memory depth is 2**ADDR_W words.
- DATA_W, 32: word width.
- WORDS_PER_BLOCK, 4: words per cache block; power of two, at least 1.
- READ_LAT, 4: cycles from read accept to ready; at least 1.
- WRITE_LAT, 4: cycles from write accept to ready; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ReadEnable  in  1  read (block fill) request from the cache controller.
- WriteEnable  in  1  write-through request from the cache controller.
- address  in  ADDR_W  word address of the request.
- write_data  in  DATA_W  word to write.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight, i.e. the state is not IDLE.
- read_block  out  WORDS_PER_BLOCK*DATA_W  block-aligned read data; word 0 occupies the LSBs.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; ready=0, busy=0, read_block=0; counter=0.
  - Storage contents are not cleared.
  - Reset mid-operation aborts the request. A pending write is not performed.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, request sampling on each rising edge:
  - WriteEnable=1: capture address and write_data; load counter with WRITE_LAT-1; go to WR_WAIT.
  - Else ReadEnable=1: capture address with its low log2(WORDS_PER_BLOCK) bits cleared; load counter with READ_LAT-1; go to RD_WAIT.
  - Write wins if both enables are high.
  - Neither high: stay in IDLE.
- RD_WAIT and WR_WAIT:
  - While counter is nonzero, decrement it each cycle.
  - At counter=0, on the next edge: ready<=1 and the state returns to IDLE.
  - Read completion: read_block is loaded with words base..base+WORDS_PER_BLOCK-1 on that same edge.
  - Write completion: storage[captured address] is written with the captured data on that same edge.
- Latency: ready is high in exactly the cycle that starts LAT rising edges after the accepting edge.
  - LAT=1 means ready is high in the cycle right after the accept.
- Ready pulse: ready is high for exactly one cycle, then cleared. busy is 0 during the ready cycle.
- read_block hold: keeps its value until the next read completes. Writes do not change it.
- No abort: once a request is accepted, changes on ReadEnable, WriteEnable, address or write_data are ignored until completion.
- Back-to-back requests:
  - A request held high in the ready cycle is accepted on the edge that ends that cycle.
  - So the minimum spacing between ready pulses is LAT+1 cycles.
  - The controller drops its enable upon seeing ready, so no duplicate request is accepted.
- Read-after-write: a write completed before a read is accepted is visible in that read's read_block.
- Address range: the block read wraps modulo 2**ADDR_W. It cannot exceed memory because the base is block-aligned.
- Counter width: $clog2(max(READ_LAT,WRITE_LAT)+1) bits.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, RD_WAIT, WR_WAIT).
  - default latency constants.
  - block-offset width function clog2(WORDS_PER_BLOCK).
- Sub-module mem_array:
  - synchronous storage, 2**ADDR_W x DATA_W.
  - one word write port.
  - one registered block read port with a load enable.
- main_memory_responder holds the FSM, latency counter, request capture and ready/busy generation.

Test Plan:
- Reset: rst=0 while RD_WAIT is in progress -> ready=0, busy=0, read_block=0 immediately; no ready pulse after release.
- Read latency: preload words 8..11 with 0xA0..0xA3; ReadEnable=1, address=10 -> ready pulses exactly 4 cycles after accept, read_block={0xA3,0xA2,0xA1,0xA0}, busy=1 for cycles 1..3.
- Write then read: WriteEnable=1, address=5, data=0xDEADBEEF -> ready after 4 cycles; then read at address 4 -> word 1 of read_block=0xDEADBEEF, and read_block is unchanged by the write itself.
- Priority and no-abort: ReadEnable=WriteEnable=1 at address 3 -> a write occurs. Then start a read, drop ReadEnable after 1 cycle and change address -> ready still pulses at 4 cycles with the original block.
- Reset mid-write: accept a write of 0x1234 to address 7, assert rst=0 at cycle 2 -> address 7 keeps its old value and no ready pulse occurs.
- Boundaries: READ_LAT=WRITE_LAT=1 -> ready is high in the cycle after accept. With the enable held high, ready repeats every 2 cycles. Reading at address 1023 returns the block at 1020..1023.

Source files
------------

// File: rtl/main_memory_responder_pkg.sv
// Shared types and constants for the main-memory responder.
// State encoding, default latencies and block-offset helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_WPB       = 4;
    localparam int DEF_READ_LAT  = 4;
    localparam int DEF_WRITE_LAT = 4;

    // Number of address bits that select a word inside a block.
    function automatic int blk_off_w(input int wpb);
        return $clog2(wpb);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-controller to main-memory request/response bundle.
// The controller is the master; the responder is the slave.
interface main_memory_responder_if #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4
);
    logic                              ReadEnable;
    logic                              WriteEnable;
    logic [ADDR_W-1:0]                 address;
    logic [DATA_W-1:0]                 write_data;
    logic                              ready;
    logic                              busy;
    logic [WORDS_PER_BLOCK*DATA_W-1:0] read_block;

    modport master (
        output ReadEnable, WriteEnable, address, write_data,
        input  ready, busy, read_block
    );

    modport slave (
        input  ReadEnable, WriteEnable, address, write_data,
        output ready, busy, read_block
    );
endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Word-wide storage with one write port and a registered block read port.
// Contents survive reset; only the block output register is cleared.
module mem_array #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic [DATA_W-1:0]                 wdata,
    input  logic                              load,
    input  logic [ADDR_W-1:0]                 base,
    output logic [WORDS_PER_BLOCK*DATA_W-1:0] block
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Single-word write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Block read register; word 0 lands in the LSBs and holds until reloaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block <= '0;
        end else if (load) begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                block[w*DATA_W +: DATA_W] <= mem[base + ADDR_W'(w)];
            end
        end
    end
endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder: accepts block reads and single-word writes,
// waits a fixed latency, then pulses ready for one cycle.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_BLOCK = DEF_WPB,
    parameter int READ_LAT        = DEF_READ_LAT,
    parameter int WRITE_LAT       = DEF_WRITE_LAT
) (
    input logic                    clk,
    input logic                    rst,
    main_memory_responder_if.slave bus
);
    localparam int CNT_W = $clog2(max_int(READ_LAT, WRITE_LAT) + 1);
    localparam int OFF_W = blk_off_w(WORDS_PER_BLOCK);

    localparam logic [ADDR_W-1:0] BLK_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              accept_wr;
    logic              accept_rd;
    logic              rd_done;
    logic              wr_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: write has priority; waits end when the counter hits zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.WriteEnable) begin
                    state_nxt = WR_WAIT;
                end else if (bus.ReadEnable) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state strobes: request accepts and completions.
    always_comb begin
        accept_wr = 1'b0;
        accept_rd = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        bus.busy  = (state != IDLE);
        unique case (state)
            IDLE: begin
                accept_wr = bus.WriteEnable;
                accept_rd = !bus.WriteEnable && bus.ReadEnable;
            end
            RD_WAIT: rd_done = (cnt == '0);
            WR_WAIT: wr_done = (cnt == '0);
            default: ;
        endcase
    end

    // Request capture and latency countdown; inputs are ignored once busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            req_addr <= '0;
            req_data <= '0;
        end else if (accept_wr) begin
            cnt      <= WR_LOAD;
            req_addr <= bus.address;
            req_data <= bus.write_data;
        end else if (accept_rd) begin
            cnt      <= RD_LOAD;
            req_addr <= bus.address & BLK_MASK;
        end else if ((state != IDLE) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // One-cycle completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ready <= 1'b0;
        end else begin
            bus.ready <= rd_done || wr_done;
        end
    end

    mem_array #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_done),
        .waddr (req_addr),
        .wdata (req_data),
        .load  (rd_done),
        .base  (req_addr),
        .block (bus.read_block)
    );
endmodule
